// File: rtl/div3_sched.sv
// Round-robin scheduler feeding a shared two-stage divide-by-3 pipeline.
// Requesters compete for S1; S2 holds the result until the consumer takes it.
module div3_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_quotient,
  output logic [1:0]                    rsp_remainder,
  output logic [15:0]                   accept_count
);

  logic                  r_s1_valid;
  logic [DATA_WIDTH-1:0] r_s1_data;
  logic [ID_WIDTH-1:0]   r_s1_id;
  logic                  r_s2_valid;
  logic [DATA_WIDTH-1:0] r_s2_quot;
  logic [1:0]            r_s2_rem;
  logic [ID_WIDTH-1:0]   r_s2_id;
  logic [ID_WIDTH-1:0]   r_ptr;
  logic [15:0]           r_accept_count;

  logic                  w_s2_adv;
  logic                  w_s1_adv;
  logic                  w_fire;
  logic                  w_found;
  logic [ID_WIDTH-1:0]   w_grant_id;
  logic [ID_WIDTH-1:0]   w_scan_idx;
  logic [DATA_WIDTH-1:0] w_req_data [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_quot;
  logic [1:0]            w_div_rem;
  logic [2:0]            w_div_t;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_req_data[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  assign w_s2_adv = !r_s2_valid || rsp_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign w_fire   = |req_ready;

  // Scan from the priority pointer; ID arithmetic wraps since NUM_REQ is a power of two.
  always_comb begin
    w_found    = 1'b0;
    w_grant_id = '0;
    w_scan_idx = '0;
    req_ready  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_scan_idx = r_ptr + k[ID_WIDTH-1:0];
      if (!w_found && req_valid[w_scan_idx]) begin
        w_found    = 1'b1;
        w_grant_id = w_scan_idx;
      end
    end
    if (w_found && w_s1_adv && !rst) begin
      req_ready[w_grant_id] = 1'b1;
    end
  end

  // Restoring long division by 3: the partial remainder never exceeds 2,
  // and subtracting 3 from a 3..5 value equals adding 1 to its low two bits.
  always_comb begin
    w_quot    = '0;
    w_div_rem = '0;
    w_div_t   = '0;
    for (int b = DATA_WIDTH - 1; b >= 0; b--) begin
      w_div_t = {w_div_rem, r_s1_data[b]};
      if (w_div_t >= 3'd3) begin
        w_quot[b] = 1'b1;
        w_div_rem = w_div_t[1:0] + 2'd1;
      end else begin
        w_div_rem = w_div_t[1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid     <= 1'b0;
      r_s1_data      <= '0;
      r_s1_id        <= '0;
      r_s2_valid     <= 1'b0;
      r_s2_quot      <= '0;
      r_s2_rem       <= '0;
      r_s2_id        <= '0;
      r_ptr          <= '0;
      r_accept_count <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= w_fire;
        if (w_fire) begin
          r_s1_data <= w_req_data[w_grant_id];
          r_s1_id   <= w_grant_id;
        end
      end
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_quot <= w_quot;
          r_s2_rem  <= w_div_rem;
          r_s2_id   <= r_s1_id;
        end
      end
      if (w_fire) begin
        r_ptr          <= w_grant_id + 1'b1;
        r_accept_count <= r_accept_count + 16'd1;
      end
    end
  end

  assign rsp_valid     = r_s2_valid;
  assign rsp_id        = r_s2_id;
  assign rsp_quotient  = r_s2_quot;
  assign rsp_remainder = r_s2_rem;
  assign accept_count  = r_accept_count;

endmodule

// File: tb/tb_div3_sched.sv
// Directed bench for div3_sched: reset, single op, round-robin burst,
// arithmetic boundaries, backpressure and mid-flight reset.
module tb_div3_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_quotient;
  logic [1:0]  rsp_remainder;
  logic [15:0] accept_count;

  int checks   = 0;
  int failures = 0;

  div3_sched #(.DATA_WIDTH(8), .NUM_REQ(4), .ID_WIDTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_quotient  (rsp_quotient),
    .rsp_remainder (rsp_remainder),
    .accept_count  (accept_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_rsp(input string tag, input int v, input int id, input int q, input int r);
    check({tag, "_valid"}, 32'(rsp_valid), 32'(v));
    if (v != 0) begin
      check({tag, "_id"}, 32'(rsp_id), 32'(id));
      check({tag, "_quot"}, 32'(rsp_quotient), 32'(q));
      check({tag, "_rem"}, 32'(rsp_remainder), 32'(r));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] ops [4];
    int         exp_q [4];
    int         exp_r [4];
    ops[0] = 8'd0;   exp_q[0] = 0;  exp_r[0] = 0;
    ops[1] = 8'd3;   exp_q[1] = 1;  exp_r[1] = 0;
    ops[2] = 8'd254; exp_q[2] = 84; exp_r[2] = 2;
    ops[3] = 8'd255; exp_q[3] = 85; exp_r[3] = 0;

    rst       = 1'b1;
    req_valid = 4'b1111;
    req_data  = '0;
    rsp_ready = 1'b0;
    #1;
    check("ready_in_reset", 32'(req_ready), 0);
    tick();
    tick();
    check("ready_in_reset2", 32'(req_ready), 0);
    check_rsp("reset", 0, 0, 0, 0);
    check("reset_id", 32'(rsp_id), 0);
    check("reset_quot", 32'(rsp_quotient), 0);
    check("reset_rem", 32'(rsp_remainder), 0);
    check("reset_count", 32'(accept_count), 0);
    req_valid = 4'b0000;
    rst       = 1'b0;
    $display("step reset done");

    // Single operand 200 -> 66 rem 2, two cycles after accept
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    req_data[7:0] = 8'd200;
    #1;
    check("single_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    check("single_count", 32'(accept_count), 1);
    check("single_early", 32'(rsp_valid), 0);
    tick();
    check_rsp("single", 1, 0, 66, 2);
    tick();
    check("single_drain", 32'(rsp_valid), 0);
    $display("step single 200 done");

    // Round-robin burst from ptr=0
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'(3*i + 1);
    req_valid = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      #1;
      check($sformatf("rr_ready_c%0d", c), 32'(req_ready), (c < 4) ? (32'h1 << c) : 32'h0);
      if (c >= 2) check_rsp($sformatf("rr_rsp_c%0d", c), 1, c - 2, c - 2, 1);
      else        check_rsp($sformatf("rr_rsp_c%0d", c), 0, 0, 0, 0);
      tick();
      if (c < 4) req_valid[c] = 1'b0;
      $display("step rr cycle %0d", c);
    end
    check_rsp("rr_drain", 0, 0, 0, 0);
    check("rr_count", 32'(accept_count), 4);

    // Boundary operands through requester 0, one per cycle
    for (int c = 0; c < 6; c++) begin
      req_valid     = (c < 4) ? 4'b0001 : 4'b0000;
      req_data[7:0] = (c < 4) ? ops[c] : 8'd0;
      #1;
      check($sformatf("bnd_ready_c%0d", c), 32'(req_ready), (c < 4) ? 32'h1 : 32'h0);
      if (c >= 2) check_rsp($sformatf("bnd_rsp_c%0d", c), 1, 0, exp_q[c-2], exp_r[c-2]);
      tick();
      $display("step boundary cycle %0d", c);
    end
    req_valid = 4'b0000;
    check_rsp("bnd_drain", 0, 0, 0, 0);
    check("bnd_count", 32'(accept_count), 8);

    // Backpressure: ptr=1, all pending, rsp_ready low for 4 cycles
    req_data  = {8'd20, 8'd17, 8'd13, 8'd9};
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    #1;
    check("bp_ready_c0", 32'(req_ready), 32'h2);
    tick();
    check("bp_ready_c1", 32'(req_ready), 32'h4);
    check("bp_valid_c1", 32'(rsp_valid), 0);
    tick();
    for (int c = 2; c < 4; c++) begin
      check($sformatf("bp_ready_c%0d", c), 32'(req_ready), 0);
      check_rsp($sformatf("bp_hold_c%0d", c), 1, 1, 4, 1);
      check($sformatf("bp_count_c%0d", c), 32'(accept_count), 10);
      tick();
    end
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    #1;
    check_rsp("bp_out0", 1, 1, 4, 1);
    tick();
    check_rsp("bp_out1", 1, 2, 5, 2);
    tick();
    check_rsp("bp_drain", 0, 0, 0, 0);
    check("bp_count", 32'(accept_count), 10);
    $display("step backpressure done");

    // Mid-flight reset with both stages full (ptr=3 going in)
    rsp_ready     = 1'b0;
    req_valid     = 4'b0001;
    req_data[7:0] = 8'd30;
    #1;
    check("mr_ready0", 32'(req_ready), 32'h1);
    tick();
    check("mr_ready1", 32'(req_ready), 32'h1);
    tick();
    check_rsp("mr_full", 1, 0, 10, 0);
    rst = 1'b1;
    #1;
    check("mr_ready_rst", 32'(req_ready), 0);
    tick();
    rst       = 1'b0;
    req_valid = 4'b1111;
    #1;
    check("mr_valid", 32'(rsp_valid), 0);
    check("mr_count", 32'(accept_count), 0);
    check("mr_quot", 32'(rsp_quotient), 0);
    check("mr_ptr", 32'(req_ready), 32'h1);
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("mr_stale_c%0d", c), 32'(rsp_valid), 0);
    end
    $display("step mid reset done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
